// File: rtl/stopwatch_tx_report_pkg.sv
// Shared constants, state encoding and snapshot layout for the stopwatch report transmitter.
package stopwatch_tx_report_pkg;

  localparam int unsigned FRAME_LEN = 15;
  localparam int unsigned IDX_W     = 4;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] mode;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] msec;
  } snap_t;

endpackage

// File: rtl/stopwatch_tx_report_bin2ascii2.sv
// Two-digit ASCII decimal conversion of a 7-bit value, saturating at "99".
module bin2ascii2
  import stopwatch_tx_report_pkg::*;
(
  input  logic [6:0] bin_i,
  output logic [7:0] tens_o,
  output logic [7:0] ones_o
);

  logic [6:0] sat_c;

  always_comb begin
    sat_c  = (bin_i > 7'd99) ? 7'd99 : bin_i;
    tens_o = ASCII_ZERO + 8'(sat_c / 7'd10);
    ones_o = ASCII_ZERO + 8'(sat_c % 7'd10);
  end

endmodule

// File: rtl/stopwatch_tx_report.sv
// Formats a snapshot of the stopwatch time as "M HH:MM:SS.CC\r\n" and streams it into the TX FIFO.
module stopwatch_tx_report
  import stopwatch_tx_report_pkg::*;
#(
  parameter bit          REPORT_ON_CHANGE = 1'b1,
  parameter int unsigned FRAME_LEN        = stopwatch_tx_report_pkg::FRAME_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       run_md,
  input  logic       clear,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] msec,
  input  logic       send_req,
  input  logic       tx_full,
  output logic       wr_en,
  output logic [7:0] tx_data,
  output logic       busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  snap_t            snap_q, snap_d;
  logic [7:0]       prev_mode_q;
  logic [7:0]       mode_c;
  logic             trigger_c;

  logic [7:0] hh_t, hh_o, mm_t, mm_o, ss_t, ss_o, cc_t, cc_o;

  bin2ascii2 u_hh (.bin_i(7'(snap_q.hour)), .tens_o(hh_t), .ones_o(hh_o));
  bin2ascii2 u_mm (.bin_i(7'(snap_q.min)),  .tens_o(mm_t), .ones_o(mm_o));
  bin2ascii2 u_ss (.bin_i(7'(snap_q.sec)),  .tens_o(ss_t), .ones_o(ss_o));
  bin2ascii2 u_cc (.bin_i(snap_q.msec),     .tens_o(cc_t), .ones_o(cc_o));

  // Mode code priority: clear beats stopped beats run-mode select.
  always_comb begin
    if (clear)        mode_c = ASCII_C;
    else if (!enable) mode_c = ASCII_S;
    else if (!run_md) mode_c = ASCII_R;
    else              mode_c = ASCII_H;
    trigger_c = send_req || (REPORT_ON_CHANGE && (mode_c != prev_mode_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      snap_q      <= '0;
      prev_mode_q <= ASCII_S;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      snap_q      <= snap_d;
      prev_mode_q <= mode_c;
    end
  end

  // Pending stays set through the one-cycle IDLE gap so busy covers it; it clears on re-entry to SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger_c || pend_q) begin
          state_d     = ST_SEND;
          idx_d       = '0;
          pend_d      = 1'b0;
          snap_d.mode = mode_c;
          snap_d.hour = hour;
          snap_d.min  = min;
          snap_d.sec  = sec;
          snap_d.msec = msec;
        end
      end
      ST_SEND: begin
        wr_en = !tx_full;
        if (trigger_c) pend_d = 1'b1;
        if (wr_en) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_SEND) || pend_q;

  always_comb begin
    tx_data = 8'h00;
    case (idx_q)
      4'd0:    tx_data = snap_q.mode;
      4'd1:    tx_data = ASCII_SPACE;
      4'd2:    tx_data = hh_t;
      4'd3:    tx_data = hh_o;
      4'd4:    tx_data = ASCII_COLON;
      4'd5:    tx_data = mm_t;
      4'd6:    tx_data = mm_o;
      4'd7:    tx_data = ASCII_COLON;
      4'd8:    tx_data = ss_t;
      4'd9:    tx_data = ss_o;
      4'd10:   tx_data = ASCII_DOT;
      4'd11:   tx_data = cc_t;
      4'd12:   tx_data = cc_o;
      4'd13:   tx_data = ASCII_CR;
      4'd14:   tx_data = ASCII_LF;
      default: tx_data = 8'h00;
    endcase
  end

endmodule
